regfile_onehot: RTL and testbench
=================================

REGFILE_ONEHOT -- requirements
Module: regfile_onehot

Interface
REQ-001 Parameter: WIDTH, default 16, bit width of each register and of every data port.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-low (0 = reset asserted).
REQ-004 Port: wr_sel  input  8  one-hot write select (bit i selects register i); 8'h00 = no write.
REQ-005 Port: wr_data  input  WIDTH  write data.
REQ-006 Port: rd_addr1  input  3  read port 1 register index.
REQ-007 Port: rd_addr2  input  3  read port 2 register index.
REQ-008 Port: rd_data1  output  WIDTH  read port 1 data.
REQ-009 Port: rd_data2  output  WIDTH  read port 2 data.
REQ-010 Port: err  output  1  sticky flag: a multi-hot wr_sel has been seen.
REQ-011 Port: wr_cnt  output  8  count of accepted writes, modulo 256.

Function
REQ-012 The block SHALL hold 8 registers R0..R7 of WIDTH bits; all are writable, and none is hardwired.
REQ-013 When wr_sel has exactly one bit i set, the block SHALL load wr_data into Ri at the next rising clk edge; this is an accepted write.
REQ-014 When wr_sel == 8'h00, the block SHALL leave all registers unchanged.
REQ-015 When wr_sel has two or more bits set, the block SHALL leave all registers unchanged and SHALL set err to 1 at that edge.
REQ-016 err SHALL stay at 1 until reset; subsequent legal writes SHALL NOT clear it.
REQ-017 rd_data1 SHALL be a combinational function of rd_addr1 and the register array, with zero-cycle latency and the current value of R[rd_addr1].
REQ-018 rd_data2 SHALL behave the same way for rd_addr2; both ports are independent and may address the same register.
REQ-019 The data written at edge N SHALL be visible on the read ports after edge N (one-cycle write-to-read latency), except as modified by REQ-027.
REQ-020 wr_cnt SHALL increment by 1 on each accepted write, SHALL wrap from 8'hFF to 8'h00, and SHALL NOT change on no-write or multi-hot cycles.
REQ-021 On a multi-hot cycle, wr_cnt SHALL hold and the only state change SHALL be err.

Reset
REQ-022 While rst == 0, the block SHALL immediately, without waiting for clk, force R0..R7 = 0, err = 0 and wr_cnt = 0.
REQ-023 Because the read paths are combinational, rd_data1 and rd_data2 SHALL read 0 during reset.
REQ-024 A write presented in the cycle that rst deasserts SHALL be ignored if rst is still 0 at that rising edge.
REQ-025 An assertion of rst mid-operation SHALL discard all register contents and the err and wr_cnt history.

Configuration
REQ-026 Macro RF_BYPASS_EN SHALL select write-to-read bypass.
REQ-027 With RF_BYPASS_EN defined: when a read address equals the index of the accepted write in the same cycle, that port SHALL return wr_data combinationally.
  - Multi-hot and no-write cycles SHALL NOT bypass.
REQ-028 With RF_BYPASS_EN undefined: reads SHALL always return the stored value; the new value appears after the edge.

Verification
REQ-029 Reset then read all addresses -> rd_data1 = rd_data2 = 16'h0000, err = 0, wr_cnt = 0.
REQ-030 Write 16'hA5A0+i to Ri using wr_sel = 1<<i for i = 0..7, then read pairs (0,7), (3,3), (5,2) -> values match; wr_cnt = 8.
REQ-031 wr_sel = 8'h18 with wr_data = 16'hFFFF -> R3 and R4 unchanged, err = 1, wr_cnt unchanged.
  - A following legal write to R1 -> R1 updated, err still 1.
REQ-032 Same cycle: wr_sel = 8'h04, wr_data = 16'h1234, rd_addr1 = 2.
  - With RF_BYPASS_EN: rd_data1 = 16'h1234 before the edge.
  - Without RF_BYPASS_EN: rd_data1 = old R2 before the edge and 16'h1234 after it.
REQ-033 Issue 256 accepted writes -> wr_cnt wraps to 8'h00; 257 writes -> 8'h01.
REQ-034 Assert rst asynchronously between edges after loading data -> all outputs read 0 immediately.
  - A write held across rst deassertion with rst still 0 at the edge -> no register is updated.

Source files
------------

// File: rtl/regfile_onehot.sv
// Eight-entry register file with a one-hot write select, two combinational read ports,
// a sticky multi-hot error flag and an accepted-write counter. Optional bypass: RF_BYPASS_EN.
module regfile_onehot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [2:0]       rd_addr1,
  input  logic [2:0]       rd_addr2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  output logic             err,
  output logic [7:0]       wr_cnt
);

  // Number of set bits in the write select.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  // Index of the highest set bit; only meaningful when exactly one bit is set.
  function automatic logic [2:0] onehot_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  logic [WIDTH-1:0] regs_r [8];
  logic             err_r;
  logic [7:0]       cnt_r;
  logic [3:0]       sel_pop_s;
  logic [2:0]       wr_idx_s;
  logic             wr_acc_s;
  logic             multi_s;

  // Classify the write select; nothing counts as a write while reset is held.
  always_comb begin
    sel_pop_s = popcount8(wr_sel);
    wr_idx_s  = onehot_index(wr_sel);
    if (rst) begin
      wr_acc_s = (sel_pop_s == 4'd1);
      multi_s  = (sel_pop_s >= 4'd2);
    end else begin
      wr_acc_s = 1'b0;
      multi_s  = 1'b0;
    end
  end

  // Register array: cleared asynchronously, loaded only on an accepted write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_acc_s) begin
      regs_r[wr_idx_s] <= wr_data;
    end
  end

  // Sticky error flag and modulo-256 accepted-write counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
      cnt_r <= 8'd0;
    end else begin
      if (multi_s) begin
        err_r <= 1'b1;
      end
      if (wr_acc_s) begin
        cnt_r <= cnt_r + 8'd1;
      end
    end
  end

  // Read ports: stored value, optionally overridden by the same-cycle accepted write.
  always_comb begin
    rd_data1 = regs_r[rd_addr1];
    rd_data2 = regs_r[rd_addr2];
`ifdef RF_BYPASS_EN
    if (wr_acc_s && (rd_addr1 == wr_idx_s)) begin
      rd_data1 = wr_data;
    end else begin
      rd_data1 = regs_r[rd_addr1];
    end
    if (wr_acc_s && (rd_addr2 == wr_idx_s)) begin
      rd_data2 = wr_data;
    end else begin
      rd_data2 = regs_r[rd_addr2];
    end
`else
    if (wr_acc_s) begin
      rd_data1 = regs_r[rd_addr1];
      rd_data2 = regs_r[rd_addr2];
    end else begin
      rd_data1 = regs_r[rd_addr1];
      rd_data2 = regs_r[rd_addr2];
    end
`endif
  end

  assign err    = err_r;
  assign wr_cnt = cnt_r;

endmodule

// File: tb/tb_regfile_onehot.sv
// Scoreboard bench for regfile_onehot: stimulus pushes predicted outputs, a negedge monitor compares.
module tb_regfile_onehot;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    wr_sel = 8'h00;
  logic [W-1:0]  wr_data = '0;
  logic [2:0]    rd_addr1 = 3'd0;
  logic [2:0]    rd_addr2 = 3'd0;
  logic [W-1:0]  rd_data1, rd_data2;
  logic          err;
  logic [7:0]    wr_cnt;

  regfile_onehot #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .err(err), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           id;
    logic [W-1:0] e1;
    logic [W-1:0] e2;
    logic         eerr;
    logic [7:0]   ecnt;
  } exp_t;

  exp_t         sbq[$];
  int           checks = 0;
  int           fails = 0;
  int           step_id = 0;

  // Reference model: plain array, flag and integer counter.
  logic [W-1:0] mdl [8];
  bit           merr;
  int           mcnt;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    merr = 1'b0;
    mcnt = 0;
  endtask

  function automatic exp_t predict();
    exp_t e;
    e.id   = step_id;
    e.e1   = mdl[rd_addr1];
    e.e2   = mdl[rd_addr2];
    e.eerr = merr;
    e.ecnt = 8'(mcnt % 256);
`ifdef RF_BYPASS_EN
    if (rst && $countones(wr_sel) == 1) begin
      if (wr_sel[rd_addr1]) e.e1 = wr_data;
      if (wr_sel[rd_addr2]) e.e2 = wr_data;
    end
`endif
    return e;
  endfunction

  task automatic push_check();
    sbq.push_back(predict());
    step_id++;
  endtask

  // One cycle: drive, queue the pre-edge expectation, then apply the write rules at the edge.
  task automatic step(input logic [7:0] sel, input logic [W-1:0] d,
                      input logic [2:0] a1, input logic [2:0] a2);
    wr_sel = sel; wr_data = d; rd_addr1 = a1; rd_addr2 = a2;
    push_check();
    @(posedge clk);
    if (rst) begin
      if ($countones(sel) == 1) begin
        for (int i = 0; i < 8; i++) if (sel[i]) mdl[i] = d;
        mcnt = (mcnt + 1) % 256;
      end else if ($countones(sel) > 1) begin
        merr = 1'b1;
      end
    end
    #1;
  endtask

  task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  // Monitor: outputs are stable away from the rising edge, so compare every queued entry here.
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      cmp("rd_data1", e.id, 32'(rd_data1), 32'(e.e1));
      cmp("rd_data2", e.id, 32'(rd_data2), 32'(e.e2));
      cmp("err",      e.id, 32'(err),      32'(e.eerr));
      cmp("wr_cnt",   e.id, 32'(wr_cnt),   32'(e.ecnt));
    end
  end

  function automatic logic [7:0] rand_sel();
    int k;
    logic [7:0] s;
    k = $urandom_range(0, 9);
    if (k < 2) begin
      s = 8'h00;
    end else if (k < 9) begin
      s = 8'h01 << $urandom_range(0, 7);
    end else begin
      s = 8'($urandom_range(0, 255));
      if ($countones(s) < 2) s = 8'h81;
    end
    return s;
  endfunction

  initial begin
    model_reset();
    #1;
    // Reset held: every address reads zero.
    for (int i = 0; i < 8; i++) step(8'h00, '0, 3'(i), 3'(7 - i));
    rst = 1'b1;
    for (int i = 0; i < 8; i++) step(8'h00, '0, 3'(i), 3'(7 - i));

    // Load R0..R7 and read back pairs.
    for (int i = 0; i < 8; i++) step(8'h01 << i, 16'hA5A0 + 16'(i), 3'(i), 3'(7 - i));
    step(8'h00, '0, 3'd0, 3'd7);
    step(8'h00, '0, 3'd3, 3'd3);
    step(8'h00, '0, 3'd5, 3'd2);

    // Multi-hot write, then a legal write to R1.
    step(8'h18, 16'hFFFF, 3'd3, 3'd4);
    step(8'h02, 16'h7777, 3'd3, 3'd4);
    step(8'h00, '0, 3'd1, 3'd4);

    // Same-cycle read of the register being written.
    step(8'h04, 16'h1234, 3'd2, 3'd2);
    step(8'h00, '0, 3'd2, 3'd2);

    // Randomized traffic.
    for (int n = 0; n < 300; n++)
      step(rand_sel(), 16'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

    // Asynchronous reset between edges: outputs must be zero before any clock edge.
    wr_sel = 8'h00; rd_addr1 = 3'd2; rd_addr2 = 3'd5;
    #1;
    rst = 1'b0;
    model_reset();
    push_check();
    @(posedge clk);
    #1;
    // Write held while reset is still low at the edge: ignored.
    step(8'h01, 16'hFFFF, 3'd0, 3'd1);
    rst = 1'b1;
    step(8'h00, '0, 3'd0, 3'd1);

    // Counter wrap: 256 accepted writes then one more.
    for (int n = 0; n < 256; n++)
      step(8'h01 << $urandom_range(0, 7), 16'($urandom), 3'($urandom_range(0, 7)), 3'd0);
    step(8'h00, '0, 3'd0, 3'd1);
    step(8'h40, 16'hBEEF, 3'd6, 3'd6);
    step(8'h00, '0, 3'd6, 3'd7);

    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending entries expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
